sar_conversion_sequencer: RTL and testbench
===========================================

// Module: sar_conversion_sequencer
// PURPOSE
// Successive-approximation sequencer for the voltmeter's R2R and PWM DAC paths.
// - Consumes the enable_r2r_successive / enable_pwm_successive strobes from the mode-decode logic.
// - Drives a trial code onto the selected DAC, waits a mode-specific settle time, then samples
//   that path's comparator and resolves one bit per step, MSB first.
// - Publishes the finished code to the averaging/display path with a 1-cycle valid pulse.
// - Converts back-to-back while an enable is held.
// PARAMETERS
// WIDTH              8     DAC/result code width in bits (>=2)
// R2R_SETTLE_CYCLES  8     clocks held per trial bit in R2R mode (>=3)
// PWM_SETTLE_CYCLES  4096  clocks held per trial bit in PWM mode; covers RC filter settling (>=3)
// PORTS
// clk                    in   1      system clock
// reset_n                in   1      asynchronous, active-low reset
// enable_r2r_successive  in   1      request R2R-path conversions; has priority over PWM
// enable_pwm_successive  in   1      request PWM-path conversions
// comparator_r2r         in   1      raw R2R comparator pin; 1 = Vin >= Vdac
// comparator_pwm         in   1      raw PWM comparator pin; 1 = Vin >= Vdac
// dac_code               out  WIDTH  trial code to the active DAC (R2R ladder or PWM duty)
// r2r_active             out  1      conversion in progress on the R2R path
// pwm_active             out  1      conversion in progress on the PWM path
// busy                   out  1      FSM not in IDLE
// result                 out  WIDTH  last completed conversion; held until next completion
// result_valid           out  1      1-cycle pulse when result updates
// BEHAVIOUR
// Reset
// - While reset_n is low: all outputs 0, FSM in IDLE, comparator synchronizers cleared.
// - Reset is asynchronous; deassertion takes effect on the next clk edge.
// Comparator synchronization
// - Each comparator passes through its own 2-flop synchronizer.
// - Only the synchronizer of the latched mode is sampled.
// - The settle minimum of 3 covers the 2-cycle synchronizer latency.
// FSM states: IDLE, SETTLE, DECIDE, DONE.
// IDLE
// - Leaves IDLE when either enable is high.
// - Latches mode: R2R if enable_r2r_successive, else PWM.
// - Sets dac_code = 1<<(WIDTH-1), bit index = WIDTH-1.
// - Loads the settle counter with S-1 (S = settle cycles for the latched mode) and goes to SETTLE.
// SETTLE
// - Counter decrements each clock; at 0 go to DECIDE. S cycles total.
// DECIDE (1 cycle)
// - If the synced comparator is 0, clear dac_code[idx].
// - If idx > 0: set dac_code[idx-1], decrement idx, reload counter, go to SETTLE.
// - If idx = 0: go to DONE.
// DONE (1 cycle)
// - result <= dac_code, result_valid = 1, then return to IDLE.
// - dac_code holds the final code until the next conversion starts.
// Timing
// - result_valid is high exactly WIDTH*(S+1)+1 clocks after the IDLE edge that sampled the enable.
// - Back-to-back conversions: IDLE costs 1 cycle between conversions.
// Active outputs
// - r2r_active/pwm_active = busy qualified by the latched mode.
// - They are one-hot or both 0; never both 1.
// Abort
// - Triggered when the latched mode's enable goes low in any non-IDLE state, or the other enable
//   wins priority, i.e. R2R enable rises during a PWM conversion.
// - Next state is IDLE; dac_code <= 0; no result_valid; result unchanged.
// - A new conversion may start on the following cycle.
// Simultaneous enables
// - R2R is chosen; PWM is ignored until the R2R enable drops.
// Reset mid-conversion
// - Immediate return to the reset values; no partial result is published.
// Counter and code widths
// - Counter width is $clog2(max(R2R_SETTLE_CYCLES, PWM_SETTLE_CYCLES)).
// - Codes are unsigned; there is no wrap, because dac_code only clears or sets single bits.
// TESTING (WIDTH=8, R2R_SETTLE=4, PWM_SETTLE=16; bench comparator = (vin >= dac_code))
// T1 R2R conversion
// - Stimulus: R2R enable held, vin=0xA5.
// - Required: result=0xA5; result_valid 41 clks after start; r2r_active=1 and pwm_active=0 throughout.
// T2 Rail codes (R2R)
// - Stimulus: vin=0xFF, then vin=0x00.
// - Required: results 0xFF and 0x00; dac_code trial sequence for 0x00 is 80,40,20,..,01.
// T3 PWM conversion
// - Stimulus: PWM enable held, vin=0x3C.
// - Required: result=0x3C; result_valid 137 clks after start; back-to-back pulses 138 clks apart.
// T4 Priority and abort
// - Stimulus: R2R enable raised mid-PWM conversion.
// - Required: PWM conversion aborts with no valid pulse; dac_code=0 for 1 cycle; R2R conversion
//   completes with the correct result.
// T5 Enable drop
// - Stimulus: R2R enable dropped after 20 clks.
// - Required: busy=0 next cycle, result keeps its previous value, no result_valid pulse.
// T6 Reset mid-conversion
// - Stimulus: reset_n pulsed low mid-conversion, asynchronous to clk.
// - Required: all outputs 0 immediately; clean full conversion after release.

Source files
------------

// File: rtl/sar_conversion_sequencer.sv
// sar_conversion_sequencer: MSB-first successive-approximation sequencer for the R2R and PWM DAC paths.
module sar_conversion_sequencer #(
  parameter int WIDTH             = 8,
  parameter int R2R_SETTLE_CYCLES = 8,
  parameter int PWM_SETTLE_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_r2r_successive,
  input  logic             enable_pwm_successive,
  input  logic             comparator_r2r,
  input  logic             comparator_pwm,
  output logic [WIDTH-1:0] dac_code,
  output logic             r2r_active,
  output logic             pwm_active,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);
  localparam int CW = $clog2(R2R_SETTLE_CYCLES > PWM_SETTLE_CYCLES ? R2R_SETTLE_CYCLES : PWM_SETTLE_CYCLES);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] R2R_LOAD = CW'(R2R_SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] PWM_LOAD = CW'(PWM_SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync_r2r, r_sync_pwm;
  logic             r_mode_r2r, w_mode_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] w_dac_nxt, w_result_nxt;
  logic             w_valid_nxt, w_abort, w_cmp;
  assign busy       = r_state != IDLE;
  assign r2r_active = busy & r_mode_r2r;
  assign pwm_active = busy & ~r_mode_r2r;
  assign w_cmp      = r_mode_r2r ? r_sync_r2r[1] : r_sync_pwm[1];
  // Losing the own enable, or R2R pre-empting a PWM conversion, abandons the conversion.
  assign w_abort    = busy && (r_mode_r2r ? !enable_r2r_successive
                                          : (!enable_pwm_successive || enable_r2r_successive));
  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode_r2r;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_dac_nxt    = dac_code;
    w_result_nxt = result;
    w_valid_nxt  = 1'b0;
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_dac_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: if (enable_r2r_successive || enable_pwm_successive) begin
          w_mode_nxt  = enable_r2r_successive;
          w_state_nxt = SETTLE;
          w_dac_nxt   = WIDTH'(1) << (WIDTH - 1);
          w_idx_nxt   = IW'(WIDTH - 1);
          w_cnt_nxt   = enable_r2r_successive ? R2R_LOAD : PWM_LOAD;
        end
        SETTLE: if (r_cnt == '0) w_state_nxt = DECIDE;
                else w_cnt_nxt = r_cnt - 1'b1;
        DECIDE: begin
          if (!w_cmp) w_dac_nxt[r_idx] = 1'b0;
          if (r_idx != '0) begin
            w_dac_nxt[r_idx - 1'b1] = 1'b1;
            w_idx_nxt   = r_idx - 1'b1;
            w_cnt_nxt   = r_mode_r2r ? R2R_LOAD : PWM_LOAD;
            w_state_nxt = SETTLE;
          end else w_state_nxt = DONE;
        end
        DONE: begin
          w_result_nxt = dac_code;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sync_r2r   <= '0;
      r_sync_pwm   <= '0;
      r_mode_r2r   <= 1'b0;
      r_cnt        <= '0;
      r_idx        <= '0;
      dac_code     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sync_r2r   <= {r_sync_r2r[0], comparator_r2r};
      r_sync_pwm   <= {r_sync_pwm[0], comparator_pwm};
      r_mode_r2r   <= w_mode_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      dac_code     <= w_dac_nxt;
      result       <= w_result_nxt;
      result_valid <= w_valid_nxt;
    end
endmodule

// File: tb/tb_sar_conversion_sequencer.sv
// tb_sar_conversion_sequencer: directed checks of R2R/PWM conversions, priority, abort and reset.
module tb_sar_conversion_sequencer;
  localparam int W = 8;
  logic         clk = 1'b0, reset_n = 1'b0, en_r = 1'b0, en_p = 1'b0;
  logic [W-1:0] vin = '0;
  logic [W-1:0] dac_code, result, prev_dac = '0;
  logic         r2r_active, pwm_active, busy, result_valid;
  logic [W-1:0] trace[$];
  int           n_checks = 0, n_fail = 0;

  sar_conversion_sequencer #(.WIDTH(W), .R2R_SETTLE_CYCLES(4), .PWM_SETTLE_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .enable_r2r_successive(en_r), .enable_pwm_successive(en_p),
    .comparator_r2r(vin >= dac_code), .comparator_pwm(vin >= dac_code),
    .dac_code(dac_code), .r2r_active(r2r_active), .pwm_active(pwm_active),
    .busy(busy), .result(result), .result_valid(result_valid));

  always #5 clk = ~clk;

  // Distinct trial codes seen while converting.
  always @(negedge clk) begin
    if (busy && dac_code != prev_dac) trace.push_back(dac_code);
    prev_dac = dac_code;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency counts clocks from the start edge (first posedge seen) to the valid pulse; -1 on timeout.
  task automatic wait_valid(input bit r2r, output int lat, output bit act_ok);
    int c = 0;
    lat = -1;
    act_ok = 1'b1;
    while (c < 400) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (result_valid) begin
        lat = c - 1;
        break;
      end
      if (r2r_active !== r2r || pwm_active !== !r2r) act_ok = 1'b0;
    end
  endtask

  initial begin
    int lat, lat2;
    bit ok, saw;
    #12;
    check("rst_dac", 32'(dac_code), 0);
    check("rst_busy", 32'({busy, r2r_active, pwm_active}), 0);
    check("rst_result", 32'({result, result_valid}), 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    // T1
    vin = 8'hA5; en_r = 1'b1;
    wait_valid(1'b1, lat, ok);
    check("t1_result", 32'(result), 32'hA5);
    check("t1_latency", lat, 41);
    check("t1_active", 32'(ok), 1);
    en_r = 1'b0;
    @(negedge clk);
    check("t1_pulse_width", 32'(result_valid), 0);
    check("t1_dac_hold", 32'(dac_code), 32'hA5);
    // T2
    vin = 8'hFF; en_r = 1'b1;
    wait_valid(1'b1, lat, ok);
    check("t2_result_ff", 32'(result), 32'hFF);
    check("t2_latency_ff", lat, 41);
    en_r = 1'b0;
    @(negedge clk);
    trace.delete();
    vin = 8'h00; en_r = 1'b1;
    wait_valid(1'b1, lat, ok);
    check("t2_result_00", 32'(result), 0);
    check("t2_trace_len", trace.size(), 9);
    for (int i = 0; i < 8 && i < trace.size(); i++) begin
      logic [W-1:0] e;
      e = 8'h80 >> i;
      check($sformatf("t2_trial%0d", i), 32'(trace[i]), 32'(e));
    end
    en_r = 1'b0;
    @(negedge clk);
    // T3
    vin = 8'h3C; en_p = 1'b1;
    wait_valid(1'b0, lat, ok);
    check("t3_result", 32'(result), 32'h3C);
    check("t3_latency", lat, 137);
    check("t3_active", 32'(ok), 1);
    wait_valid(1'b0, lat2, ok);
    check("t3_spacing", lat2 + 1, 138);
    check("t3_result2", 32'(result), 32'h3C);
    en_p = 1'b0;
    @(negedge clk);
    // T4
    saw = 1'b0;
    en_p = 1'b1;
    repeat (30) @(negedge clk) saw |= result_valid;
    vin = 8'h5A; en_r = 1'b1;
    @(negedge clk);
    saw |= result_valid;
    check("t4_no_valid", 32'(saw), 0);
    check("t4_abort_dac", 32'(dac_code), 0);
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_result_kept", 32'(result), 32'h3C);
    wait_valid(1'b1, lat, ok);
    check("t4_r2r_result", 32'(result), 32'h5A);
    check("t4_r2r_latency", lat, 41);
    check("t4_r2r_active", 32'(ok), 1);
    en_r = 1'b0; en_p = 1'b0;
    repeat (2) @(negedge clk);
    // T5
    saw = 1'b0;
    vin = 8'h77; en_r = 1'b1;
    repeat (20) @(negedge clk) saw |= result_valid;
    en_r = 1'b0;
    @(negedge clk);
    saw |= result_valid;
    check("t5_busy", 32'(busy), 0);
    check("t5_result_kept", 32'(result), 32'h5A);
    check("t5_no_valid", 32'(saw), 0);
    // T6
    vin = 8'h99; en_r = 1'b1;
    repeat (15) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_dac", 32'(dac_code), 0);
    check("t6_rst_flags", 32'({busy, r2r_active, pwm_active, result_valid}), 0);
    check("t6_rst_result", 32'(result), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_valid(1'b1, lat, ok);
    check("t6_result", 32'(result), 32'h99);
    check("t6_latency", lat, 41);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
